// File: rtl/animation_scene_sequencer.sv
// animation_scene_sequencer: steps the display through NUM_SCENES scenes.
// A scene ends when the ten-second timer reports done or when skip is pulsed.
// Between scenes there is a one-cycle GAP with timer_en low, which clears the timer.
// The block also generates the frame-rate tick and the per-scene frame count.
// Optional feature: define ANIM_LOOP_EN to loop the sequence until stop.
// With the macro defined, finished pulses once per completed pass.
module animation_scene_sequencer #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned FRAME_HZ   = 10,
  parameter int unsigned NUM_SCENES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       skip,
  input  logic       timer_done,
  output logic       timer_en,
  output logic [3:0] scene,
  output logic [7:0] frame,
  output logic       frame_tick,
  output logic       busy,
  output logic       finished
);

  localparam int unsigned DIV   = CLK_HZ / FRAME_HZ;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [3:0]       LAST_SCENE = 4'(NUM_SCENES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StGap,
    StFinish
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       scene_q, scene_d;
  logic [7:0]       frame_q, frame_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             fin_q, fin_d;

  logic sync1_q, sync2_q, sync3_q;
  logic done_evt;

  // Bring timer_done into the clk domain; sync3 holds the previous value for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= timer_done;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // One event per low->high edge. A held-high input produces only one event.
  assign done_evt = sync2_q & ~sync3_q;

  // State, scene, frame, divider and finished-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      scene_q <= 4'd0;
      frame_q <= 8'd0;
      div_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scene_q <= scene_d;
      frame_q <= frame_d;
      div_q   <= div_d;
      fin_q   <= fin_d;
    end
  end

  // Next-state logic. Priority is stop > skip > done_evt.
  // skip and done_evt have the same effect.
  always_comb begin
    state_d = state_q;
    scene_d = scene_q;
    frame_d = frame_q;
    div_d   = div_q;
    fin_d   = 1'b0;

    case (state_q)
      StIdle: begin
        scene_d = 4'd0;
        frame_d = 8'd0;
        div_d   = '0;
        // start together with stop leaves the block idle.
        if (start && !stop) begin
          state_d = StPlay;
        end
      end

      StPlay: begin
        if (stop) begin
          state_d = StIdle;
          scene_d = 4'd0;
          frame_d = 8'd0;
          div_d   = '0;
        end else if (skip || done_evt) begin
          // A scene change takes precedence over a coincident frame tick.
          frame_d = 8'd0;
          div_d   = '0;
          if (scene_q < LAST_SCENE) begin
            state_d = StGap;
            scene_d = scene_q + 4'd1;
          end else begin
`ifdef ANIM_LOOP_EN
            // Wrap to scene 0 through GAP so the timer still gets cleared.
            state_d = StGap;
            scene_d = 4'd0;
            fin_d   = 1'b1;
`else
            state_d = StFinish;
            scene_d = 4'd0;
            fin_d   = 1'b1;
`endif
          end
        end else if (div_q == DIV_LAST) begin
          div_d   = '0;
          frame_d = frame_q + 8'd1;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      StGap: begin
        div_d = '0;
        if (stop) begin
          state_d = StIdle;
          scene_d = 4'd0;
          frame_d = 8'd0;
        end else begin
          state_d = StPlay;
        end
      end

      StFinish: begin
        state_d = StIdle;
        scene_d = 4'd0;
        frame_d = 8'd0;
        div_d   = '0;
      end

      default: begin
        state_d = StIdle;
        scene_d = 4'd0;
        frame_d = 8'd0;
        div_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from registered state, so reset clears them immediately.
  always_comb begin
    timer_en   = (state_q == StPlay);
    busy       = (state_q == StPlay) || (state_q == StGap);
    frame_tick = (state_q == StPlay) && (div_q == DIV_LAST);
    scene      = scene_q;
    frame      = frame_q;
    finished   = fin_q;
  end

endmodule
